// File: rtl/mem_port_arbiter.sv
// Arbitrates the single off-chip memory port between the I-cache and D-cache.
// One block transaction is in flight at a time. D wins contention, but a streak limit keeps I from starving.
module mem_port_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    // state   | meaning
    // IDLE    | sample requests, grant on the clock edge
    // SERVE_I | I-cache transaction held on the memory port
    // SERVE_D | D-cache transaction held on the memory port
    // DONE    | ready pulse cycle; lets the owner drop its level request
    typedef enum logic [1:0] {S_IDLE, S_SERVE_I, S_SERVE_D, S_DONE} state_t;

    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);

    state_t            state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              i_req, d_req, d_wins;

    assign i_req  = i_mem_read;
    assign d_req  = d_mem_read | d_mem_write;
    assign d_wins = d_req && (!i_req || MAX_D_STREAK == 0 || int'(streak_q) < MAX_D_STREAK);

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (d_wins) begin
                    state_d     = S_SERVE_D;
                    addr_d      = d_mem_addr;
                    wdata_d     = d_mem_wdata;
                    // read+write together is a writeback; the read is dropped
                    mem_write_d = d_mem_write;
                    mem_read_d  = !d_mem_write;
                    if (i_req && streak_q != {SW{1'b1}}) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (i_req) begin
                    state_d    = S_SERVE_I;
                    addr_d     = i_mem_addr;
                    mem_read_d = 1'b1;
                    streak_d   = '0;
                end
            end
            S_SERVE_I: begin
                if (mem_ready) begin
                    state_d     = S_DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    i_rdata_d   = mem_rdata;
                    i_ready_d   = 1'b1;
                end
            end
            S_SERVE_D: begin
                if (mem_ready) begin
                    state_d     = S_DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (!mem_write_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_ready_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            streak_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign i_mem_rdata = i_rdata_q;
    assign i_mem_ready = i_ready_q;
    assign d_mem_rdata = d_rdata_q;
    assign d_mem_ready = d_ready_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;

endmodule
